// File: rtl/reset_sequencer.sv
// reset_sequencer: staged peripheral/CPU reset release with soft reset and watchdog restart.
module reset_sequencer #(
    parameter int STAGE_DELAY = 16,
    parameter int WDT_WIDTH   = 16,
    parameter int WDT_TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic [1:0] reset_cause,
    output logic       wdt_expired
);
    typedef enum logic [1:0] {HOLD, PERIPH, RUN} state_t;
    localparam logic [7:0]           STAGE_LAST = 8'(STAGE_DELAY - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST   = WDT_WIDTH'(WDT_TIMEOUT);
    localparam logic [WDT_WIDTH-1:0] WDT_ONE    = WDT_WIDTH'(1);
    state_t               state_q, state_d;
    logic [7:0]           stage_q, stage_d;
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic [1:0]           cause_q, cause_d;
    logic                 expired_q, expired_d;
    logic                 periph_reset_q, periph_reset_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 ready_q, ready_d;
    logic                 timeout;
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q + 8'd1;
        wdt_d     = '0;
        cause_d   = cause_q;
        expired_d = expired_q;
        timeout   = (state_q == RUN) && wdt_enable && !wdt_kick && (wdt_q == WDT_LAST);
        case (state_q)
            HOLD: if (stage_q == STAGE_LAST) begin
                state_d = PERIPH;
                stage_d = '0;
            end
            PERIPH: if (stage_q == STAGE_LAST) begin
                state_d = RUN;
                stage_d = '0;
            end
            RUN: begin
                stage_d = '0;
                wdt_d   = wdt_enable ? (wdt_kick ? '0 : wdt_q + WDT_ONE) : '0;
                // watchdog outranks a coincident soft request
                if (timeout) begin
                    state_d   = HOLD;
                    wdt_d     = '0;
                    cause_d   = 2'b10;
                    expired_d = 1'b1;
                end else if (soft_reset_req) begin
                    state_d = HOLD;
                    wdt_d   = '0;
                    cause_d = 2'b01;
                end
            end
            default: begin
                state_d = HOLD;
                stage_d = '0;
            end
        endcase
        periph_reset_d = (state_d == HOLD);
        cpu_reset_d    = (state_d != RUN);
        ready_d        = (state_d == RUN);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HOLD;
            stage_q        <= '0;
            wdt_q          <= '0;
            cause_q        <= 2'b00;
            expired_q      <= 1'b0;
            periph_reset_q <= 1'b1;
            cpu_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            wdt_q          <= wdt_d;
            cause_q        <= cause_d;
            expired_q      <= expired_d;
            periph_reset_q <= periph_reset_d;
            cpu_reset_q    <= cpu_reset_d;
            ready_q        <= ready_d;
        end
    end
    assign periph_reset = periph_reset_q;
    assign cpu_reset    = cpu_reset_q;
    assign ready        = ready_q;
    assign reset_cause  = cause_q;
    assign wdt_expired  = expired_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random checks against an elapsed-time reference model.
module tb_reset_sequencer;
    localparam int D  = 4;
    localparam int WW = 8;
    localparam int WT = 10;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset_req = 1'b0;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       periph_reset, cpu_reset, ready, wdt_expired;
    logic [1:0] reset_cause;
    int         checks = 0;
    int         errors = 0;
    int         m_t = 0;
    int         m_w = 0;
    logic [1:0] m_cause = 2'b00;
    logic       m_exp = 1'b0;

    reset_sequencer #(.STAGE_DELAY(D), .WDT_WIDTH(WW), .WDT_TIMEOUT(WT)) dut (
        .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req),
        .wdt_enable(wdt_enable), .wdt_kick(wdt_kick),
        .periph_reset(periph_reset), .cpu_reset(cpu_reset), .ready(ready),
        .reset_cause(reset_cause), .wdt_expired(wdt_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // m_t counts edges since the current sequence began; m_w counts unkicked RUN cycles
    task automatic model_step();
        if (reset) begin
            m_t = 0; m_w = 0; m_cause = 2'b00; m_exp = 1'b0;
        end else if (m_t >= 2*D) begin
            if (wdt_enable && !wdt_kick && m_w == WT) begin
                m_t = 0; m_w = 0; m_cause = 2'b10; m_exp = 1'b1;
            end else if (soft_reset_req) begin
                m_t = 0; m_w = 0; m_cause = 2'b01;
            end else begin
                m_w = (wdt_enable && !wdt_kick) ? m_w + 1 : 0;
            end
        end else begin
            m_t++;
            m_w = 0;
        end
    endtask

    task automatic step(input logic s = 1'b0, input logic k = 1'b0, input logic r = 1'b0);
        reset = r;
        soft_reset_req = s;
        wdt_kick = k;
        @(posedge clk);
        model_step();
        #1;
        chk("periph_reset", {1'b0, periph_reset}, {1'b0, m_t < D});
        chk("cpu_reset", {1'b0, cpu_reset}, {1'b0, m_t < 2*D});
        chk("ready", {1'b0, ready}, {1'b0, m_t >= 2*D});
        chk("reset_cause", reset_cause, m_cause);
        chk("wdt_expired", {1'b0, wdt_expired}, {1'b0, m_exp});
        soft_reset_req = 1'b0;
        wdt_kick = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        chk("rst_periph", {1'b0, periph_reset}, 2'd1);
        chk("rst_ready", {1'b0, ready}, 2'd0);
        steps(3);
        chk("ext_periph_edge3", {1'b0, periph_reset}, 2'd1);
        step();
        chk("ext_periph_edge4", {1'b0, periph_reset}, 2'd0);
        chk("ext_cpu_edge4", {1'b0, cpu_reset}, 2'd1);
        steps(3);
        chk("ext_ready_edge7", {1'b0, ready}, 2'd0);
        step();
        chk("ext_ready_edge8", {1'b0, ready}, 2'd1);
        chk("ext_cause", reset_cause, 2'b00);

        step(1);
        chk("soft_hold", {1'b0, periph_reset & cpu_reset}, 2'd1);
        chk("soft_cause", reset_cause, 2'b01);
        steps(4);
        chk("soft_periph_rel", {1'b0, periph_reset}, 2'd0);
        step(1);
        steps(2);
        step();
        chk("soft_ignored_periph", {1'b0, ready}, 2'd1);

        wdt_enable = 1'b1;
        steps(10);
        chk("wdt_before_timeout", {1'b0, ready}, 2'd1);
        step();
        chk("wdt_timeout_hold", {1'b0, periph_reset}, 2'd1);
        chk("wdt_cause", reset_cause, 2'b10);
        chk("wdt_expired_set", {1'b0, wdt_expired}, 2'd1);
        steps(8);
        chk("wdt_rerun_ready", {1'b0, ready}, 2'd1);
        chk("wdt_expired_sticky", {1'b0, wdt_expired}, 2'd1);

        steps(10);
        step(0, 1);
        chk("kick_at_terminal", {1'b0, ready}, 2'd1);
        for (int i = 0; i < 200; i++) step(0, (i % 8) == 0);
        chk("kick_200_ready", {1'b0, ready}, 2'd1);

        step(0, 1);
        steps(10);
        step(1);
        chk("coincide_cause", reset_cause, 2'b10);
        chk("coincide_ready", {1'b0, ready}, 2'd0);

        steps(5);
        step(0, 0, 1);
        chk("rst_periph_cause", reset_cause, 2'b00);
        chk("rst_periph_exp", {1'b0, wdt_expired}, 2'd0);
        steps(4);
        chk("rst_periph_rel4", {1'b0, periph_reset}, 2'd0);
        steps(4);
        chk("rst_periph_rel8", {1'b0, ready}, 2'd1);
        steps(11);
        chk("rst_run_timeout", {1'b0, wdt_expired}, 2'd1);
        steps(8);
        step(0, 0, 1);
        chk("rst_run_exp", {1'b0, wdt_expired}, 2'd0);
        chk("rst_run_periph", {1'b0, periph_reset}, 2'd1);
        steps(8);
        chk("rst_run_ready", {1'b0, ready}, 2'd1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) wdt_enable = ~wdt_enable;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The module SHALL have parameter STAGE_DELAY, default 16: number of clk cycles each reset stage is held (range 2-255).
REQ-002 The module SHALL have parameter WDT_WIDTH, default 16: watchdog counter width in bits.
REQ-003 The module SHALL have parameter WDT_TIMEOUT, default 16'hFFFF: watchdog terminal count (1 to 2^WDT_WIDTH-1).
REQ-004 Port clk, input, 1: single system clock, sourced from the clock manager's buffered output; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset, sourced from the clock manager's reset output (asserted until lock plus settle count).
REQ-006 Port soft_reset_req, input, 1: single-cycle soft reset request from the Picoblaze output-port strobe.
REQ-007 Port wdt_enable, input, 1: level; 1 enables the watchdog.
REQ-008 Port wdt_kick, input, 1: single-cycle watchdog restart.
REQ-009 Port periph_reset, output, 1: active-high synchronous reset to the peripheral/bus logic.
REQ-010 Port cpu_reset, output, 1: active-high synchronous reset to the Picoblaze core.
REQ-011 Port ready, output, 1: high only when both stage resets are released.
REQ-012 Port reset_cause, output, 2: cause of the last sequence: 00 external, 01 soft, 10 watchdog, 11 unused.
REQ-013 Port wdt_expired, output, 1: sticky flag, set by any watchdog timeout.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 The FSM SHALL have three states: HOLD (periph_reset=1, cpu_reset=1, ready=0), PERIPH (periph_reset=0, cpu_reset=1, ready=0), RUN (periph_reset=0, cpu_reset=0, ready=1).
REQ-016 The stage counter SHALL be 8 bits, cleared on every state entry, and increment once per cycle in HOLD and PERIPH.
REQ-017 HOLD->PERIPH SHALL occur when the stage counter equals STAGE_DELAY-1, so periph_reset falls exactly STAGE_DELAY edges after the first edge with reset=0.
REQ-018 PERIPH->RUN SHALL occur when the stage counter equals STAGE_DELAY-1, so cpu_reset and ready change exactly STAGE_DELAY edges after periph_reset falls.
REQ-019 In RUN, soft_reset_req=1 SHALL cause RUN->HOLD on the next edge and set reset_cause=01.
REQ-020 soft_reset_req SHALL be ignored in HOLD and PERIPH.
REQ-021 The watchdog counter (WDT_WIDTH bits) SHALL be held at 0 outside RUN and whenever wdt_enable=0.
REQ-022 In RUN with wdt_enable=1, wdt_kick=1 SHALL clear the counter; otherwise it SHALL increment by 1.
REQ-023 A timeout SHALL occur when the counter equals WDT_TIMEOUT and wdt_kick=0 in that cycle; the counter never wraps.
REQ-024 A timeout SHALL cause RUN->HOLD, set reset_cause=10, and set wdt_expired=1.
REQ-025 wdt_kick=1 coincident with counter==WDT_TIMEOUT SHALL clear the counter; no timeout occurs.
REQ-026 If soft_reset_req and a timeout coincide, watchdog SHALL win: reset_cause=10 and wdt_expired=1.
REQ-027 reset_cause SHALL hold its value through the subsequent HOLD/PERIPH/RUN sequence until the next cause event.

Reset
REQ-028 While reset=1, on each edge: state=HOLD, stage and watchdog counters=0, periph_reset=1, cpu_reset=1, ready=0, reset_cause=00, wdt_expired=0.
REQ-029 Assertion of reset in any state, including mid-sequence, SHALL take effect on the next edge and restart the full sequence from HOLD.
REQ-030 soft or watchdog resets SHALL NOT clear wdt_expired; only reset SHALL clear it.

Verification (STAGE_DELAY=4, WDT_WIDTH=8, WDT_TIMEOUT=10)
REQ-031 The bench SHALL cover: reset high 5 cycles then low -> periph_reset falls at edge 4, cpu_reset/ready change at edge 8, reset_cause=00, wdt_expired=0.
REQ-032 The bench SHALL cover: in RUN, one-cycle soft_reset_req -> next edge periph_reset=cpu_reset=1, reset_cause=01, then release at +4/+8 edges; a request pulsed during PERIPH is ignored.
REQ-033 The bench SHALL cover: wdt_enable=1, no kick in RUN -> timeout 11 edges after RUN entry, HOLD entered, reset_cause=10, wdt_expired=1, which stays 1 after re-entering RUN.
REQ-034 The bench SHALL cover: kick asserted exactly when the counter=10 -> counter 0, no reset; kicks every 8 cycles for 200 cycles -> ready stays 1.
REQ-035 The bench SHALL cover: soft_reset_req and timeout in the same cycle -> reset_cause=10, wdt_expired=1.
REQ-036 The bench SHALL cover: reset asserted for 1 cycle during PERIPH and during RUN after a timeout -> all outputs at reset values, wdt_expired=0, full 4/8-edge sequence restarts.
